// File: rtl/led_pattern_scheduler.sv
// LED pattern scheduler: steps through a 4-entry {colour, dwell} table,
// either manually while paused or on a millisecond timebase while running.
module led_pattern_scheduler #(
  parameter int unsigned TICK_DIV = 12000,
  parameter int unsigned DWELL_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               play_pulse,
  input  logic               step_pulse,
  input  logic               wr_en,
  input  logic [1:0]         wr_addr,
  input  logic [2:0]         wr_color,
  input  logic [DWELL_W-1:0] wr_dwell,
  output logic [2:0]         rgb,
  output logic               running,
  output logic [1:0]         step_idx
);

  localparam int unsigned    PreW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(TICK_DIV - 1);

  // Two legal codes out of four so a corrupted register is detectable.
  typedef enum logic [1:0] {
    StPaused  = 2'b01,
    StRunning = 2'b10
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         step_q, step_d;
  logic [PreW-1:0]    pre_q, pre_d;
  logic [DWELL_W-1:0] ms_q, ms_d;

  logic [2:0]         color_q [4];
  logic [DWELL_W-1:0] dwell_q [4];

  logic [DWELL_W-1:0] dwell_cur;
  logic [DWELL_W:0]   dwell_eff;
  logic [DWELL_W:0]   ms_inc;

  // Dwell of zero is treated as one millisecond; the table read is pre-write.
  always_comb begin
    dwell_cur = dwell_q[step_q];
    dwell_eff = (dwell_cur == '0) ? (DWELL_W + 1)'(1) : {1'b0, dwell_cur};
    ms_inc    = {1'b0, ms_q} + (DWELL_W + 1)'(1);
  end

  // Next-state: play toggles and wins over everything, then step/advance.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    pre_d   = pre_q;
    ms_d    = ms_q;
    case (state_q)
      StPaused: begin
        pre_d = '0;
        if (play_pulse) begin
          state_d = StRunning;
          ms_d    = '0;
        end else if (step_pulse) begin
          step_d = step_q + 2'd1;
          ms_d   = '0;
        end
      end
      StRunning: begin
        if (play_pulse) begin
          state_d = StPaused;
          pre_d   = '0;
          ms_d    = '0;
        end else if (pre_q == PreMax) begin
          // Millisecond tick: prescaler wraps, dwell accounting advances.
          pre_d = '0;
          if (ms_inc >= dwell_eff) begin
            step_d = step_q + 2'd1;
            ms_d   = '0;
          end else begin
            ms_d = ms_inc[DWELL_W-1:0];
          end
        end else begin
          pre_d = pre_q + PreW'(1);
        end
      end
      default: begin
        state_d = StPaused;
        pre_d   = '0;
        ms_d    = '0;
      end
    endcase
  end

  // Control state registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StPaused;
      step_q  <= 2'd0;
      pre_q   <= '0;
      ms_q    <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      pre_q   <= pre_d;
      ms_q    <= ms_d;
    end
  end

  // Pattern table: reset to R, G, B, off at 250 ms each; writable in any state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      color_q[0] <= 3'b001;
      color_q[1] <= 3'b010;
      color_q[2] <= 3'b100;
      color_q[3] <= 3'b000;
      dwell_q[0] <= DWELL_W'(250);
      dwell_q[1] <= DWELL_W'(250);
      dwell_q[2] <= DWELL_W'(250);
      dwell_q[3] <= DWELL_W'(250);
    end else if (wr_en) begin
      color_q[wr_addr] <= wr_color;
      dwell_q[wr_addr] <= wr_dwell;
    end
  end

  // Outputs: LED drive is active-low and follows the table combinationally.
  always_comb begin
    rgb      = ~color_q[step_q];
    running  = (state_q == StRunning);
    step_idx = step_q;
  end

endmodule

// File: tb/tb_led_pattern_scheduler.sv
// Bench for led_pattern_scheduler: a time-based reference model predicts
// every change of {running, step_idx, rgb}; a monitor compares DUT changes.
module tb_led_pattern_scheduler;

  localparam int unsigned T  = 4;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          play_pulse = 1'b0;
  logic          step_pulse = 1'b0;
  logic          wr_en = 1'b0;
  logic [1:0]    wr_addr = 2'd0;
  logic [2:0]    wr_color = 3'd0;
  logic [DW-1:0] wr_dwell = '0;
  logic [2:0]    rgb;
  logic          running;
  logic [1:0]    step_idx;

  led_pattern_scheduler #(
    .TICK_DIV (T),
    .DWELL_W  (DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .play_pulse (play_pulse),
    .step_pulse (step_pulse),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_color   (wr_color),
    .wr_dwell   (wr_dwell),
    .rgb        (rgb),
    .running    (running),
    .step_idx   (step_idx)
  );

  always #5 clk = ~clk;

  // Edge counter: after posedge n it reads n.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic       run;
    logic [1:0] step;
    logic [2:0] led;
  } obs_t;

  typedef struct {
    int   edge_n;
    obs_t obs;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   passes = 0;

  // Reference model: table plus current step, run flag and entry edge.
  logic [2:0] m_color [4];
  int         m_dwell [4];
  logic [1:0] m_step;
  logic       m_run;
  int         m_enter;
  obs_t       m_last;

  function automatic obs_t model_obs();
    obs_t o;
    o.run  = m_run;
    o.step = m_step;
    o.led  = ~m_color[m_step];
    return o;
  endfunction

  // A step entered at edge e advances at the first edge e+k*T with k >= max(dwell,1).
  function automatic bit model_advance_at(int n);
    int el;
    int d;
    el = n - m_enter;
    d  = (m_dwell[m_step] == 0) ? 1 : m_dwell[m_step];
    return m_run && (el > 0) && (el % T == 0) && (el / T >= d);
  endfunction

  task automatic model_reset();
    m_color[0] = 3'b001; m_color[1] = 3'b010; m_color[2] = 3'b100; m_color[3] = 3'b000;
    for (int i = 0; i < 4; i++) m_dwell[i] = 250;
    m_step  = 2'd0;
    m_run   = 1'b0;
    m_enter = 0;
    m_last  = model_obs();
  endtask

  // One clock cycle of stimulus; the model follows the same edge.
  task automatic drive(input bit play, input bit stp, input bit we, input logic [1:0] a,
                       input logic [2:0] c, input int d);
    obs_t o;
    play_pulse = play;
    step_pulse = stp;
    wr_en      = we;
    wr_addr    = a;
    wr_color   = c;
    wr_dwell   = DW'(d);
    @(posedge clk);
    #1;
    play_pulse = 1'b0;
    step_pulse = 1'b0;
    wr_en      = 1'b0;
    if (!rst) begin
      if (play) begin
        m_run   = ~m_run;
        m_enter = cyc;
      end else if (!m_run && stp) begin
        m_step = m_step + 2'd1;
      end else if (model_advance_at(cyc)) begin
        m_step  = m_step + 2'd1;
        m_enter = cyc;
      end
      if (we) begin
        m_color[a] = c;
        m_dwell[a] = d;
      end
      o = model_obs();
      if (o != m_last) begin
        sbq.push_back('{cyc, o});
        m_last = o;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 0);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got === req) passes++;
    else $display("FAIL %s: got %0h, required %0h", name, got, req);
  endtask

  task automatic wait_step(input logic [1:0] target, input int limit);
    int k;
    k = 0;
    while (m_step != target && k < limit) begin
      idle(1);
      k++;
    end
    if (m_step != target) begin
      checks++;
      $display("FAIL wait_step timeout: model step %0d, required %0d", m_step, target);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rgb"}, 32'(rgb), 32'(3'b110));
    check({tag, "_running"}, 32'(running), 32'd0);
    check({tag, "_step_idx"}, 32'(step_idx), 32'd0);
  endtask

  // Monitor: every observed change must match the next predicted change.
  initial begin
    obs_t prev;
    obs_t cur;
    exp_t e;
    prev = '0;
    forever begin
      @(negedge clk);
      cur = {running, step_idx, rgb};
      if (rst) begin
        prev = cur;
      end else begin
        while (sbq.size() > 0 && sbq[0].edge_n < cyc) begin
          checks++;
          e = sbq.pop_front();
          $display("FAIL missing_change: edge %0d expected %b, still %b at edge %0d",
                   e.edge_n, e.obs, cur, cyc);
        end
        if (cur != prev) begin
          checks++;
          if (sbq.size() == 0) begin
            $display("FAIL unexpected_change at edge %0d: got %b, required %b", cyc, cur, prev);
          end else begin
            e = sbq.pop_front();
            if (e.edge_n == cyc && e.obs == cur) passes++;
            else $display("FAIL scoreboard at edge %0d: got %b, required %b at edge %0d",
                          cyc, cur, e.obs, e.edge_n);
          end
        end
        prev = cur;
      end
    end
  end

  initial begin
    int k;
    model_reset();
    // Reset values with no clock edge yet.
    #1 rst = 1'b1;
    #1 check_reset_outputs("reset");
    idle(2);
    rst = 1'b0;

    // Manual stepping while paused, wraps 3 -> 0.
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 1'b0, 2'd0, 3'd0, 0);
      idle(1);
    end

    // Timed run with 2 ms per step.
    for (int a = 0; a < 4; a++) drive(1'b0, 1'b0, 1'b1, 2'(a), m_color[a], 2);
    drive(1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 0);
    idle(40);

    // Pause landing on an advance-tick edge must not advance.
    k = 0;
    while (!model_advance_at(cyc + 1) && k < 100) begin
      idle(1);
      k++;
    end
    check("advance_tick_found", 32'(model_advance_at(cyc + 1)), 32'd1);
    drive(1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 0);
    idle(6);

    // Play and step together while paused: play wins.
    drive(1'b1, 1'b1, 1'b0, 2'd0, 3'd0, 0);
    idle(3);

    // Live writes on the displayed step 2.
    wait_step(2'd2, 200);
    drive(1'b0, 1'b0, 1'b1, 2'd2, 3'b111, 2);
    drive(1'b0, 1'b0, 1'b1, 2'd2, 3'b111, 0);
    idle(30);
    drive(1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 0);

    // Randomised commands and table writes.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 39) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0,
            2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
    end

    // Reset mid-dwell on step 3, then a full 250 ms dwell from step 0.
    if (!m_run) drive(1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 0);
    wait_step(2'd3, 400);
    idle(2);
    @(negedge clk);
    #1 rst = 1'b1;
    #1 check_reset_outputs("midrun_reset");
    model_reset();
    sbq.delete();
    idle(3);
    rst = 1'b0;
    check_reset_outputs("after_release");
    drive(1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 0);
    idle(250 * T + 10);

    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/led_pattern_scheduler.md
LED_PATTERN_SCHEDULER -- requirements
Module: led_pattern_scheduler

Interface
REQ-001 SHALL have parameter TICK_DIV, default 12000, meaning clk cycles per 1 ms dwell tick (12 MHz clk); legal range >= 2.
REQ-002 SHALL have parameter DWELL_W, default 8, meaning width of the per-step dwell field in ms.
REQ-003 SHALL have port clk  in  1  single system clock; all state on rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port play_pulse  in  1  one-cycle command that toggles run/pause, already debounced and edge-detected upstream.
REQ-006 SHALL have port step_pulse  in  1  one-cycle command that advances one step while paused.
REQ-007 SHALL have port wr_en  in  1  pattern-table write strobe.
REQ-008 SHALL have port wr_addr  in  2  table entry to write.
REQ-009 SHALL have port wr_color  in  3  entry colour, active-high, bit0=R, bit1=G, bit2=B.
REQ-010 SHALL have port wr_dwell  in  DWELL_W  entry dwell in ms.
REQ-011 SHALL have port rgb  out  3  LED drive, active-low, equal to ~colour of the current step.
REQ-012 SHALL have port running  out  1  high in S_RUNNING.
REQ-013 SHALL have port step_idx  out  2  index of the displayed step.

Function
REQ-014 SHALL hold a 4-entry table of {colour, dwell}, written on any clk edge with wr_en=1, in any state.
REQ-015 SHALL implement two states: S_PAUSED and S_RUNNING.
REQ-016 SHALL transition S_PAUSED->S_RUNNING on play_pulse, and S_RUNNING->S_PAUSED on play_pulse.
REQ-017 SHALL, in S_PAUSED, advance step_idx by 1 modulo 4 on step_pulse, with wrap 3->0.
REQ-018 SHALL ignore step_pulse in S_RUNNING, and ignore step_pulse in any cycle where play_pulse is also high (play wins).
REQ-019 SHALL run the prescaler 0..TICK_DIV-1 only in S_RUNNING, emitting an internal tick on the cycle it wraps to 0; the prescaler is cleared on entering S_PAUSED.
REQ-020 SHALL keep a ms counter that is cleared on every step change and on every state change, and incremented on each tick.
REQ-021 SHALL, on a tick where ms_count+1 >= max(dwell[step_idx],1), advance step_idx by 1 modulo 4 and clear ms_count; dwell=0 behaves as 1 ms.
REQ-022 SHALL give a dwell of D ms exactly D*TICK_DIV cycles of display after the step is entered from S_RUNNING.
REQ-023 SHALL have rgb combinationally follow table[step_idx].colour, so a write to the displayed entry is visible the cycle after the write edge.
REQ-024 SHALL, when a write to the current entry's dwell coincides with an advance decision, use the pre-write dwell for that decision.
REQ-025 SHALL, when a pause arrives on the same cycle as an advance tick, pause without advancing.
REQ-026 SHALL never produce an out-of-range state; an illegal encoding recovers to S_PAUSED on the next edge.

Reset
REQ-027 SHALL, on rst, immediately and without clk, set state=S_PAUSED, step_idx=0, prescaler=0 and ms_count=0.
REQ-028 SHALL, on rst, load the table to {R=001,250}, {G=010,250}, {B=100,250}, {off=000,250}.
REQ-029 SHALL drive these output values during and after reset: rgb=3'b110, running=0, step_idx=0.
REQ-030 SHALL abandon any in-progress dwell on rst asserted mid-run, with no pending write or command surviving.

Verification
REQ-031 SHALL pass the reset-values scenario: assert rst, check outputs with no clk -> rgb=110, running=0, step_idx=0.
REQ-032 SHALL pass the paused-stepping scenario with TICK_DIV=4: step_pulse x5 while paused -> step_idx 1,2,3,0,1; rgb 101,011,111,110,101.
REQ-033 SHALL pass the timed-run scenario with TICK_DIV=4: write dwell=2 to all entries, play_pulse -> step_idx changes exactly every 8 cycles, wrapping 3->0.
REQ-034 SHALL pass the simultaneous-events scenario: play_pulse and step_pulse on the same cycle while paused -> running=1, step_idx unchanged; and pause on an advance-tick cycle -> step_idx unchanged.
REQ-035 SHALL pass the live-write scenario: while running on step 2, write entry 2 colour=111 -> rgb=000 on the next cycle; write dwell=0 -> advance after 1 tick.
REQ-036 SHALL pass the mid-run-reset scenario: assert rst mid-dwell on step 3 -> outputs at reset values immediately; after release, play_pulse -> full 250-ms dwell restarts from step 0.
